// File: rtl/sub_vga_scanout_if.sv
// rtl/sub_vga_scanout_if.sv - VRAM read port and palette write port of the VGA scanout
// master is the scanout engine; slave is the VRAM/palette host side.
interface sub_vga_scanout_if;
   logic [15:0] o_vga_addr;
   logic [3:0]  i_vga_pixel;
   logic        i_pal_we;
   logic [3:0]  i_pal_idx;
   logic [11:0] i_pal_rgb;

   modport master (
      output o_vga_addr,
      input  i_vga_pixel,
      input  i_pal_we,
      input  i_pal_idx,
      input  i_pal_rgb
   );

   modport slave (
      input  o_vga_addr,
      output i_vga_pixel,
      output i_pal_we,
      output i_pal_idx,
      output i_pal_rgb
   );
endinterface

// File: rtl/sub_vga_scanout.sv
// rtl/sub_vga_scanout.sv - 640x480 VGA scanout of a scrolled 256x256 4-bit map, 4x4 pixel replication
// Porch/sync widths are fixed offsets from the visible size; default parameters give 800x525 timing.
module sub_vga_scanout #(
   parameter int H_VISIBLE = 640,
   parameter int V_VISIBLE = 480
) (
   input  logic                     vga_clock,
   input  logic                     reset,
   sub_vga_scanout_if.master        vram,
   input  logic [7:0]               i_scroll_x,
   input  logic [7:0]               i_scroll_y,
   output logic [3:0]               o_red,
   output logic [3:0]               o_green,
   output logic [3:0]               o_blue,
   output logic                     o_hsync,
   output logic                     o_vsync,
   output logic                     o_vblank_pulse
);

   localparam int H_SYNC_START = H_VISIBLE + 16;
   localparam int H_SYNC_END   = H_SYNC_START + 96;
   localparam int H_TOTAL      = H_SYNC_END + 48;
   localparam int V_SYNC_START = V_VISIBLE + 10;
   localparam int V_SYNC_END   = V_SYNC_START + 2;
   localparam int V_TOTAL      = V_SYNC_END + 33;

   logic [9:0]  h_count;
   logic [9:0]  v_count;
   logic [7:0]  scroll_x_lat;
   logic [7:0]  scroll_y_lat;
   logic        h_last;
   logic        v_last;
   logic        active;
   logic        hsync_raw;
   logic        vsync_raw;
   logic [7:0]  map_x;
   logic [7:0]  map_y;
   logic [1:0]  active_d;
   logic [1:0]  hsync_d;
   logic [1:0]  vsync_d;
   logic [11:0] palette [16];

   assign h_last    = (h_count == 10'(H_TOTAL - 1));
   assign v_last    = (v_count == 10'(V_TOTAL - 1));
   assign active    = (h_count < 10'(H_VISIBLE)) && (v_count < 10'(V_VISIBLE));
   assign hsync_raw = !((h_count >= 10'(H_SYNC_START)) && (h_count < 10'(H_SYNC_END)));
   assign vsync_raw = !((v_count >= 10'(V_SYNC_START)) && (v_count < 10'(V_SYNC_END)));

   // 8-bit adds wrap inside the 256x256 map; x never carries into y.
   assign map_x = scroll_x_lat + h_count[9:2];
   assign map_y = scroll_y_lat + v_count[9:2];

   assign o_vblank_pulse = (h_count == 10'd0) && (v_count == 10'(V_VISIBLE));

   // Scroll is only taken on the last clock of a frame so a frame never tears.
   always_ff @(posedge vga_clock or negedge reset) begin
      if (!reset) begin
         h_count      <= 10'd0;
         v_count      <= 10'd0;
         scroll_x_lat <= 8'd0;
         scroll_y_lat <= 8'd0;
      end else if (h_last) begin
         h_count <= 10'd0;
         if (v_last) begin
            v_count      <= 10'd0;
            scroll_x_lat <= i_scroll_x;
            scroll_y_lat <= i_scroll_y;
         end else begin
            v_count <= v_count + 10'd1;
         end
      end else begin
         h_count <= h_count + 10'd1;
      end
   end

   // Address, then VRAM latency, then palette register: sync/active ride a matching 3-stage delay.
   always_ff @(posedge vga_clock or negedge reset) begin
      if (!reset) begin
         vram.o_vga_addr <= 16'h0000;
         active_d        <= 2'b00;
         hsync_d         <= 2'b11;
         vsync_d         <= 2'b11;
         o_hsync         <= 1'b1;
         o_vsync         <= 1'b1;
         o_red           <= 4'h0;
         o_green         <= 4'h0;
         o_blue          <= 4'h0;
      end else begin
         if (active) begin
            vram.o_vga_addr <= {map_y, map_x};
         end
         active_d <= {active_d[0], active};
         hsync_d  <= {hsync_d[0], hsync_raw};
         vsync_d  <= {vsync_d[0], vsync_raw};
         o_hsync  <= hsync_d[1];
         o_vsync  <= vsync_d[1];
         {o_red, o_green, o_blue} <= active_d[1] ? palette[vram.i_vga_pixel] : 12'h000;
      end
   end

   // A lookup in the same cycle as a write sees the old entry.
   always_ff @(posedge vga_clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < 16; i++) begin
            palette[i] <= {i[3:0], i[3:0], i[3:0]};
         end
      end else if (vram.i_pal_we) begin
         palette[vram.i_pal_idx] <= vram.i_pal_rgb;
      end
   end

endmodule

// File: tb/tb_sub_vga_scanout.sv
// tb/tb_sub_vga_scanout.sv - self-checking bench for sub_vga_scanout on a reduced 96x20 raster
// A reference model pushes expected pipeline outputs into a queue popped three clocks later.
module tb_sub_vga_scanout;

   localparam int H_VIS = 96;
   localparam int V_VIS = 20;
   localparam int H_TOT = 256;
   localparam int V_TOT = 65;
   localparam int FRAME = H_TOT * V_TOT;

   logic       vga_clock = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] scroll_x;
   logic [7:0] scroll_y;
   logic [3:0] red;
   logic [3:0] green;
   logic [3:0] blue;
   logic       hsync;
   logic       vsync;
   logic       vblank;
   logic [3:0] vram_xor = 4'h0;

   sub_vga_scanout_if vif ();

   sub_vga_scanout #(.H_VISIBLE(H_VIS), .V_VISIBLE(V_VIS)) dut (
      .vga_clock      (vga_clock),
      .reset          (reset),
      .vram           (vif.master),
      .i_scroll_x     (scroll_x),
      .i_scroll_y     (scroll_y),
      .o_red          (red),
      .o_green        (green),
      .o_blue         (blue),
      .o_hsync        (hsync),
      .o_vsync        (vsync),
      .o_vblank_pulse (vblank)
   );

   always #5 vga_clock = ~vga_clock;

   // VRAM: one clock of read latency, data = low address nibble (optionally inverted)
   always @(posedge vga_clock) vif.i_vga_pixel <= vif.o_vga_addr[3:0] ^ vram_xor;

   typedef struct {
      logic       act;
      logic       hs;
      logic       vs;
      logic [3:0] pix;
   } sb_t;

   typedef struct {
      int          frame;
      int          h;
      int          v;
      logic [7:0]  sx;
      logic [7:0]  sy;
      logic [15:0] exp_addr;
   } vec_t;

   sb_t         q[$];
   int          mh, mv, mframe;
   logic [7:0]  msx, msy;
   logic [11:0] mpal [16];
   logic [15:0] maddr;
   int          errors = 0;
   int          checks = 0;
   int          cyc = 0;

   int   hs_fall = -1, hs_period = 0, hs_run = 0, hs_low = 0;
   int   vs_fall = -1, vs_period = 0, vs_run = 0, vs_low = 0;
   int   vb_rise = -1, vb_period = 0, vb_run = 0, vb_width = 0;
   logic prev_hs = 1'b1, prev_vs = 1'b1, prev_vb = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic timeout_fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: wait bound expired, position not reached (h=%0d v=%0d)", name, mh, mv);
   endtask

   task automatic model_reset();
      mh = 0; mv = 0; mframe = 0; msx = 8'h00; msy = 8'h00; maddr = 16'h0000;
      for (int i = 0; i < 16; i++) mpal[i] = {i[3:0], i[3:0], i[3:0]};
      q.delete();
      q.push_back('{act: 1'b0, hs: 1'b1, vs: 1'b1, pix: 4'h0});
      q.push_back('{act: 1'b0, hs: 1'b1, vs: 1'b1, pix: 4'h0});
   endtask

   task automatic step();
      sb_t         e;
      sb_t         o;
      logic [11:0] exp_rgb;
      logic        act;
      @(posedge vga_clock);
      cyc++;
      act = (mh < H_VIS) && (mv < V_VIS);
      if (act) maddr = {msy + 8'(mv >> 2), msx + 8'(mh >> 2)};
      e.act = act;
      e.hs  = !((mh >= H_VIS + 16) && (mh < H_VIS + 112));
      e.vs  = !((mv >= V_VIS + 10) && (mv < V_VIS + 12));
      e.pix = maddr[3:0] ^ vram_xor;
      q.push_back(e);
      o = q.pop_front();
      exp_rgb = o.act ? mpal[o.pix] : 12'h000;
      if (vif.i_pal_we) mpal[vif.i_pal_idx] = vif.i_pal_rgb;
      if (mh == H_TOT - 1 && mv == V_TOT - 1) begin
         msx = scroll_x;
         msy = scroll_y;
      end
      if (mh == H_TOT - 1) begin
         mh = 0;
         if (mv == V_TOT - 1) begin
            mv = 0;
            mframe++;
         end else begin
            mv++;
         end
      end else begin
         mh++;
      end
      #2;
      check("scoreboard", {vif.o_vga_addr, red, green, blue, hsync, vsync, vblank},
            {maddr, exp_rgb, o.hs, o.vs, (mh == 0 && mv == V_VIS)});
      if (prev_hs && !hsync) begin
         if (hs_fall >= 0) hs_period = cyc - hs_fall;
         hs_fall = cyc;
      end
      if (!hsync) hs_run++;
      else if (!prev_hs) begin hs_low = hs_run; hs_run = 0; end
      if (prev_vs && !vsync) begin
         if (vs_fall >= 0) vs_period = cyc - vs_fall;
         vs_fall = cyc;
      end
      if (!vsync) vs_run++;
      else if (!prev_vs) begin vs_low = vs_run; vs_run = 0; end
      if (!prev_vb && vblank) begin
         if (vb_rise >= 0) vb_period = cyc - vb_rise;
         vb_rise = cyc;
      end
      if (vblank) vb_run++;
      else if (prev_vb) begin vb_width = vb_run; vb_run = 0; end
      prev_hs = hsync;
      prev_vs = vsync;
      prev_vb = vblank;
   endtask

   task automatic run_to(input int f, input int h, input int v, input string name);
      int g = 0;
      while (!((f < 0 || mframe == f) && mh == h && mv == v) && g < 3 * FRAME) begin
         step();
         g++;
      end
      if (g >= 3 * FRAME) timeout_fail(name);
   endtask

   vec_t vecs [14];

   initial begin
      vecs[0]  = '{0,   0,  0, 8'hF0, 8'hFC, 16'h0000};
      vecs[1]  = '{0,   3,  0, 8'hF0, 8'hFC, 16'h0000};
      vecs[2]  = '{0,   4,  0, 8'hF0, 8'hFC, 16'h0001};
      vecs[3]  = '{0,  95,  0, 8'hF0, 8'hFC, 16'h0017};
      vecs[4]  = '{0,   0,  4, 8'hF0, 8'hFC, 16'h0100};
      vecs[5]  = '{0, 100,  5, 8'hF0, 8'hFC, 16'h0117};
      vecs[6]  = '{0,   7, 19, 8'hF0, 8'hFC, 16'h0401};
      vecs[7]  = '{1,   0,  0, 8'h12, 8'h34, 16'hFCF0};
      vecs[8]  = '{1,  63,  0, 8'h12, 8'h34, 16'hFCFF};
      vecs[9]  = '{1,  64,  0, 8'h12, 8'h34, 16'hFC00};
      vecs[10] = '{1,   0, 15, 8'h12, 8'h34, 16'hFFF0};
      vecs[11] = '{1,   0, 16, 8'h12, 8'h34, 16'h00F0};
      vecs[12] = '{1,  64, 16, 8'h12, 8'h34, 16'h0000};
      vecs[13] = '{2,   0,  0, 8'h12, 8'h34, 16'h3412};

      scroll_x = 8'h55;
      scroll_y = 8'h66;
      vif.i_pal_we  = 1'b0;
      vif.i_pal_idx = 4'h0;
      vif.i_pal_rgb = 12'h000;
      repeat (3) @(posedge vga_clock);
      #2;
      check("reset_addr",   vif.o_vga_addr, 16'h0000);
      check("reset_rgb",    {red, green, blue}, 12'h000);
      check("reset_hsync",  hsync, 1'b1);
      check("reset_vsync",  vsync, 1'b1);
      check("reset_vblank", vblank, 1'b0);
      model_reset();
      reset = 1'b1;

      for (int i = 0; i < 14; i++) begin
         run_to(vecs[i].frame, vecs[i].h, vecs[i].v, $sformatf("vec%0d_wait", i));
         scroll_x = vecs[i].sx;
         scroll_y = vecs[i].sy;
         step();
         check($sformatf("vec%0d_addr", i), vif.o_vga_addr, vecs[i].exp_addr);
      end

      check("hsync_period", hs_period, H_TOT);
      check("hsync_low",    hs_low, 96);
      check("vsync_period", vs_period, FRAME);
      check("vsync_low",    vs_low, 2 * H_TOT);
      check("vblank_period", vb_period, FRAME);
      check("vblank_width", vb_width, 1);

      // palette write lands on the same edge that looks up entry 5
      run_to(2, 14, 2, "pal_wait");
      vif.i_pal_we  = 1'b1;
      vif.i_pal_idx = 4'h5;
      vif.i_pal_rgb = 12'hF00;
      step();
      vif.i_pal_we  = 1'b0;
      check("pal_old", {red, green, blue}, 12'h555);
      step();
      check("pal_new", {red, green, blue}, 12'hF00);

      // asynchronous reset mid-frame, between clock edges
      run_to(2, 50, 10, "rst_wait");
      #1;
      reset = 1'b0;
      #1;
      check("async_addr",  vif.o_vga_addr, 16'h0000);
      check("async_rgb",   {red, green, blue}, 12'h000);
      check("async_hsync", hsync, 1'b1);
      check("async_vsync", vsync, 1'b1);
      check("async_vblank", vblank, 1'b0);
      repeat (2) @(posedge vga_clock);
      #2;
      vram_xor = 4'h7;
      model_reset();
      reset = 1'b1;
      step();
      check("restart_rgb1", {red, green, blue}, 12'h000);
      step();
      check("restart_rgb2", {red, green, blue}, 12'h000);
      step();
      check("restart_rgb3", {red, green, blue}, 12'h777);
      repeat (40) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
